// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - stage indices, stage masks and FSM state type for pipe_sched
package pipe_sched_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [4:0] M_IF  = 5'(1 << STG_IF);
  localparam logic [4:0] M_ID  = 5'(1 << STG_ID);
  localparam logic [4:0] M_EX  = 5'(1 << STG_EX);
  localparam logic [4:0] M_MEM = 5'(1 << STG_MEM);
  localparam logic [4:0] M_WB  = 5'(1 << STG_WB);

  typedef enum logic [1:0] {
    RUN,
    DIV_WAIT,
    REDIRECT
  } pipe_sched_state_t;

endpackage

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - merges pipeline hazards into per-stage stall/flush vectors,
// owns the IF redirect handshake, the divide-wait watchdog and the stall-cycle counter.
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int DIV_MAX = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_rmem_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        j_b_stall_i,
  input  logic        ex_div_start_i,
  input  logic        div_ready_i,
  input  logic        if_wait_i,
  input  logic        mem_wait_i,
  input  logic        exc_valid_i,
  input  logic        eret_i,
  input  logic [31:0] exc_handler_i,
  input  logic [31:0] epc_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        div_cancel_o,
  output logic        div_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam int CW = $clog2(DIV_MAX + 1);

  pipe_sched_state_t state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic              load_use;
  logic              exc_any;
  logic [31:0]       exc_pc;
  logic              div_count;

  always_comb begin
    load_use = ex_rmem_i && (ex_waddr_i != 5'd0) &&
               ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));
    exc_any  = exc_valid_i | eret_i;
    exc_pc   = exc_valid_i ? exc_handler_i : epc_i;

    stall_o       = '0;
    flush_o       = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    div_cancel_o  = 1'b0;
    state_d       = state_q;
    target_d      = target_q;
    cnt_d         = '0;
    timeout_d     = timeout_q;
    div_count     = 1'b0;

    // A redirect in flight owns IF; new exceptions are ignored until it lands.
    if (state_q != REDIRECT && exc_any) begin
      flush_o       = M_IF | M_ID | M_EX | M_MEM;
      redirect_o    = 1'b1;
      redirect_pc_o = exc_pc;
      div_cancel_o  = (state_q == DIV_WAIT);
      target_d      = exc_pc;
      state_d       = if_wait_i ? REDIRECT : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait_i) begin
            stall_o = M_IF | M_ID | M_EX | M_MEM;
            flush_o = M_WB;
          end else if (ex_div_start_i) begin
            stall_o = M_IF | M_ID | M_EX;
            flush_o = M_MEM;
            state_d = DIV_WAIT;
          end else if (load_use || j_b_stall_i) begin
            stall_o = M_IF | M_ID;
            flush_o = M_EX;
          end else if (if_wait_i) begin
            stall_o = M_IF;
            flush_o = M_ID;
          end
        end
        DIV_WAIT: begin
          if (mem_wait_i) begin
            stall_o   = M_IF | M_ID | M_EX | M_MEM;
            flush_o   = M_WB;
            div_count = 1'b1;
          end else if (div_ready_i) begin
            state_d = RUN;
          end else begin
            stall_o   = M_IF | M_ID | M_EX;
            flush_o   = M_MEM;
            div_count = 1'b1;
          end
        end
        REDIRECT: begin
          redirect_o    = 1'b1;
          redirect_pc_o = target_q;
          flush_o       = M_IF | M_ID;
          if (!if_wait_i) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    // Wait counter saturates at DIV_MAX; timeout is sticky until reset.
    if (div_count) begin
      cnt_d = (cnt_q == CW'(DIV_MAX)) ? cnt_q : cnt_q + CW'(1);
      if (cnt_d == CW'(DIV_MAX)) timeout_d = 1'b1;
    end

    if (rst_i) begin
      stall_o       = '0;
      flush_o       = '0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      div_cancel_o  = 1'b0;
    end

    stall_cycles_d = stall_cycles_q + 32'(stall_o[STG_ID]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      target_q       <= '0;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign div_timeout_o  = timeout_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule
